ps2_rx_fifo: RTL and testbench

- Core-side PS/2 receiver: consumes the emulated ps2_kbd_clk/ps2_kbd_data (or mouse) pair driven by the HPS I/O block.
- Decodes 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Buffers good bytes in a small first-word-fall-through FIFO for the keyboard/mouse decoder.
- Flags parity, framing, timeout and overflow errors.

---
 rtl/ps2_rx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : ps2_rx_fifo
// Brief    : PS/2 frame receiver with glitch filter, timeout and FWFT byte FIFO
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_rx_fifo #(
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 65535,
  parameter int FIFO_BITS = 3
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd,
  output logic [7:0]           dout,
  output logic                 empty,
  output logic [FIFO_BITS:0]   count,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 err_timeout,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int                 c_depth = 2 ** FIFO_BITS;
  localparam int                 c_to_w  = $clog2(TIMEOUT + 1);
  localparam logic [FIFO_BITS:0] c_full  = (FIFO_BITS + 1)'(c_depth);
  localparam logic [c_to_w-1:0]  c_to    = c_to_w'(TIMEOUT);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_data   = 2'd1;
  localparam logic [1:0] c_st_parity = 2'd2;
  localparam logic [1:0] c_st_stop   = 2'd3;

  // Line conditioning: bit 0 is the PS/2 clock, bit 1 the PS/2 data
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  assign w_raw = {ps2_data, ps2_clk};

  for (genvar i = 0; i < 2; i++) begin : g_cond
    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= 2'b11;
        r_cnt  <= '0;
        r_filt <= 1'b1;
      end else begin
        r_sync <= {r_sync[0], w_raw[i]};
        if (r_sync[1] == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == 4'(FILTER - 1)) begin
          r_cnt  <= '0;
          r_filt <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end

    assign w_filt[i] = r_filt;
  end

  logic r_clk_prev;
  logic w_fall;
  logic w_bit;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_clk_prev <= 1'b1;
    else          r_clk_prev <= w_filt[0];
  end

  assign w_fall = r_clk_prev & ~w_filt[0];
  assign w_bit  = w_filt[1];

  // Frame state machine
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_par;
  logic [c_to_w-1:0] r_to_cnt;
  logic              w_timeout;
  logic              w_start;
  logic              w_shift;
  logic              w_par_ld;
  logic              w_done;
  logic              w_abort;

  assign w_timeout = (r_state != c_st_idle) && (r_to_cnt == c_to);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_fall && !w_bit)                 w_state_nxt = c_st_data;
      c_st_data:   if (w_fall && (r_bit_cnt == 3'd7))    w_state_nxt = c_st_parity;
      c_st_parity: if (w_fall)                           w_state_nxt = c_st_stop;
      c_st_stop:   if (w_fall)                           w_state_nxt = c_st_idle;
      default:                                           w_state_nxt = c_st_idle;
    endcase
    // A real edge beats a coincident timeout
    if (w_timeout && !w_fall) w_state_nxt = c_st_idle;
  end

  always_comb begin
    w_start  = 1'b0;
    w_shift  = 1'b0;
    w_par_ld = 1'b0;
    w_done   = 1'b0;
    w_abort  = w_timeout & ~w_fall;
    case (r_state)
      c_st_idle:   w_start  = w_fall & ~w_bit;
      c_st_data:   w_shift  = w_fall;
      c_st_parity: w_par_ld = w_fall;
      c_st_stop:   w_done   = w_fall;
      default:     w_start  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end
      if (w_shift) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_ld) r_par <= w_bit;
      if ((r_state == c_st_idle) || w_fall) r_to_cnt <= '0;
      else                                  r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Frame verdict is registered, so the write lands one cycle after the stop edge
  logic       w_par_ok;
  logic       r_wr_en;
  logic [7:0] r_wr_byte;

  assign w_par_ok = ^{r_shift, r_par};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en     <= 1'b0;
      r_wr_byte   <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      r_wr_en     <= w_done & w_par_ok & w_bit;
      r_wr_byte   <= r_shift;
      err_parity  <= w_done & ~w_par_ok;
      err_frame   <= w_done & ~w_bit;
      err_timeout <= w_abort;
    end
  end

  // First-word-fall-through FIFO
  logic [7:0]           r_mem [c_depth];
  logic [FIFO_BITS-1:0] r_wr_ptr;
  logic [FIFO_BITS-1:0] r_rd_ptr;
  logic [FIFO_BITS:0]   r_count;
  logic                 w_full;
  logic                 w_do_rd;
  logic                 w_do_wr;

  assign w_full  = (r_count == c_full);
  assign w_do_rd = rd && (r_count != '0);
  assign w_do_wr = r_wr_en && (!w_full || w_do_rd);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= r_wr_byte;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (ovf_clr)                                overflow <= 1'b0;
      else if (r_wr_en && w_full && !w_do_rd)     overflow <= 1'b1;
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_rx_fifo
// Brief    : Directed self-checking bench for ps2_rx_fifo
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_rx_fifo;

  localparam int H = 30;  // PS/2 half period in clk_sys cycles

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd;
  logic       ovf_clr;
  logic [7:0] dout;
  logic       empty;
  logic [3:0] count;
  logic       err_parity;
  logic       err_frame;
  logic       err_timeout;
  logic       overflow;

  ps2_rx_fifo #(.FILTER(4), .TIMEOUT(100), .FIFO_BITS(3)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd          (rd),
    .dout        (dout),
    .empty       (empty),
    .count       (count),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-frame observations taken around the stop-bit clock fall
  int t_empty, t_par, n_par, t_frm, n_frm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (H) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic glitch();
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  // rd_at: negedge index (after the stop-bit fall) at which rd is raised for one cycle
  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stopv,
                            input int glitch_at, input int rd_at);
    logic [9:0] bits;
    bits = {(~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == glitch_at) glitch();
      ps2_bit(bits[i]);
    end
    ps2_data = stopv;
    repeat (H) @(negedge clk_sys);
    ps2_clk = 1'b0;
    t_empty = -1; t_par = -1; n_par = 0; t_frm = -1; n_frm = 0;
    for (int k = 1; k <= 2 * H; k++) begin
      @(negedge clk_sys);
      if (!empty && t_empty < 0) t_empty = k;
      if (err_parity) begin if (t_par < 0) t_par = k; n_par++; end
      if (err_frame)  begin if (t_frm < 0) t_frm = k; n_frm++; end
      if (k == rd_at)     rd = 1'b1;
      if (k == rd_at + 1) rd = 1'b0;
      if (k == H) ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk_sys);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, 32'(dout), 32'(exp));
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq [9];
    logic [7:0] rb  [8];
    logic [7:0] f6b;
    int lat, highs;
    seq = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'h12, 8'h59, 8'h14, 8'h77, 8'h11};
    rb  = '{8'h1C, 8'hE0, 8'h75, 8'h12, 8'h59, 8'h14, 8'h77, 8'hAA};

    ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0; ovf_clr = 1'b0; reset_n = 1'b0;
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_errs",  32'({err_parity, err_frame, err_timeout}), 32'd0);

    // Single good byte and its write latency
    send_frame(8'h1C, 1'b0, 1'b1, -1, -1);
    chk("good_lat",   32'(t_empty), 32'd8);
    chk("good_count", 32'(count), 32'd1);
    chk("good_errs",  32'(n_par + n_frm), 32'd0);
    pop("good_dout", 8'h1C);
    chk("good_empty", 32'(empty), 32'd1);

    // Fill past capacity
    for (int i = 0; i < 9; i++) begin
      send_frame(seq[i], 1'b0, 1'b1, -1, -1);
      if (i == 7) begin
        chk("fill8_count", 32'(count), 32'd8);
        chk("fill8_ovf",   32'(overflow), 32'd0);
      end
    end
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_set",   32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk_sys);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Write and read in the same cycle while full
    chk("full_head", 32'(dout), 32'hF0);
    send_frame(8'hAA, 1'b0, 1'b1, -1, 7);
    chk("wr_rd_full_count", 32'(count), 32'd8);
    chk("wr_rd_full_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop($sformatf("pop%0d", i), rb[i]);
    chk("drain_empty", 32'(empty), 32'd1);

    // Read while empty
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
    @(negedge clk_sys);
    chk("rd_empty_count", 32'(count), 32'd0);

    // Parity and framing errors
    send_frame(8'h1C, 1'b1, 1'b1, -1, -1);
    chk("par_t",     32'(t_par), 32'd7);
    chk("par_n",     32'(n_par), 32'd1);
    chk("par_nofrm", 32'(n_frm), 32'd0);
    chk("par_count", 32'(count), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, -1);
    chk("frm_t",     32'(t_frm), 32'd7);
    chk("frm_n",     32'(n_frm), 32'd1);
    chk("frm_nopar", 32'(n_par), 32'd0);
    send_frame(8'h1C, 1'b1, 1'b0, -1, -1);
    chk("both_par_t", 32'(t_par), 32'd7);
    chk("both_frm_t", 32'(t_frm), 32'd7);
    chk("both_n",     32'(n_par + n_frm), 32'd2);
    chk("both_count", 32'(count), 32'd0);

    // Glitches in idle and mid-frame
    glitch();
    send_frame(8'h5A, 1'b0, 1'b1, 4, -1);
    chk("glitch_count", 32'(count), 32'd1);
    pop("glitch_dout", 8'h5A);

    // Timeout after start plus three data bits
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk_sys);
    ps2_clk = 1'b0;
    lat = -1; highs = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk_sys);
      if (err_timeout) begin if (lat < 0) lat = n; highs++; end
      if (n == H) ps2_clk = 1'b1;
    end
    chk("to_lat",   32'(lat), 32'd108);
    chk("to_width", 32'(highs), 32'd1);
    chk("to_count", 32'(count), 32'd0);
    send_frame(8'h33, 1'b0, 1'b1, -1, -1);
    chk("to_next_count", 32'(count), 32'd1);
    pop("to_next_dout", 8'h33);

    // Reset during bit 5 with a byte already buffered
    send_frame(8'h11, 1'b0, 1'b1, -1, -1);
    f6b = 8'h6B;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(f6b[i]);
    ps2_data = f6b[4];
    repeat (H) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (H / 2) @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_dout",  32'(dout),  32'd0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    send_frame(8'h6B, 1'b0, 1'b1, -1, -1);
    chk("mrst_next_lat",   32'(t_empty), 32'd8);
    chk("mrst_next_count", 32'(count), 32'd1);
    pop("mrst_next_dout", 8'h6B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
